t_demux_1x11: RTL and testbench
===============================

# t_demux_1x11

Frame-based 1-to-11 byte distributor: the write-side counterpart of the 11-channel 8-bit selector. A byte stream arrives with a valid/ready handshake and fills an 11-entry shadow bank in channel order 0..10. When the frame is complete, all 11 channel outputs update together. Sits upstream of the 11:1 selector and supplies its x0..x10 inputs with coherent, glitch-free frames.

## Interface
Parameters:
- DATA_W, 8, width of each channel byte
- NUM_CH, 11, channel count; fixed at 11, any other value is unsupported

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins or restarts a frame
- din  in  DATA_W  stream byte
- din_valid  in  1  din holds a byte
- din_ready  out  1  block accepts din this cycle
- y0..y10  out  DATA_W each  committed channel values, registered
- ptr  out  4  next shadow slot to be filled (0..10)
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse; y0..y10 updated this cycle
- wr_en, wr_sel[3:0], wr_data[DATA_W-1:0]  in  present only with T_DEMUX_ADDR_WRITE_EN

## Operation
- Reset (asynchronous, active-high): state IDLE, ptr=0, shadow=0, y0..y10=0, frame_done=0, busy=0, din_ready=0.
- States: IDLE, FILL, COMMIT.
- IDLE: din_ready=0. If start=1 -> FILL, ptr<=0.
- FILL: din_ready=1. On din_valid&din_ready: shadow[ptr]<=din. If ptr<10, ptr<=ptr+1. If ptr==10, ptr<=0 and state -> COMMIT.
- start during FILL: ptr<=0, stay in FILL. Any byte accepted in the same cycle is discarded. Stale shadow entries are overwritten as the new frame fills.
- COMMIT: din_ready=0. y_i<=shadow[i] for all i, frame_done<=1, then -> IDLE. start in COMMIT is ignored; the source re-issues it.
- Bytes presented while din_ready=0 are not consumed. din_valid without ready creates no state change.
- ptr never exceeds 10. There is no wrap inside FILL; the transition to COMMIT resets ptr.
- Partial frames never reach y outputs.

## Timing
- din_ready is combinational from the state register only, never from din_valid.
- Throughput: 1 byte/cycle in FILL. A frame takes 11 accepting edges plus 1 COMMIT cycle. Minimum start-to-start spacing is 13 cycles (IDLE, 11x FILL, COMMIT).
- Latency: if the last byte (slot 10) is accepted at edge N, state=COMMIT for cycle N..N+1, and y0..y10 plus frame_done=1 are visible after edge N+1. frame_done drops after edge N+2.
- busy rises the cycle after start is sampled in IDLE and falls with the COMMIT->IDLE transition.
- Reset mid-frame: immediate clear. The partial frame is lost and y returns to 0.

## Configuration
- T_DEMUX_ADDR_WRITE_EN defined:
  - adds wr_en/wr_sel/wr_data.
  - wr_en=1 with wr_sel 0..10 writes y[wr_sel] directly on the next edge, in any state.
  - wr_sel 11..15 is ignored.
  - If COMMIT loads y on the same edge, the COMMIT value wins.
  - Direct writes do not touch the shadow bank or ptr.
- Not defined: ports are absent and y changes only via COMMIT or reset.

## Structure
- Shared package t_mix_pkg holds:
  - NUM_CH=11, CH_W=4, LAST_CH=4'hA
  - state typedef {IDLE, FILL, COMMIT}
  - byte typedef.
- One sub-module, t_demux_shadow_bank:
  - an 11x8 register file with write-enable + index, and a parallel read-out of all entries.
  - The top level holds the FSM, ptr, and output registers.

## Test plan
- Reset then idle: no start, din_valid=1 for 20 cycles -> din_ready=0 throughout, y0..y10=0, frame_done never asserts.
- Full frame: start, then bytes 0x10..0x1A back-to-back -> y0=0x10 ... y10=0x1A, a single frame_done pulse 1 cycle after the last accept, busy low afterward.
- Gapped frame: same bytes with din_valid toggled every other cycle -> identical y values; frame_done arrives 1 cycle after the 11th accept.
- Restart: start, bytes 0xA0..0xA4, start again, then 0x00..0x0A -> y_i=i, 0xA0..0xA4 never appear on y.
- Async reset asserted after the 6th byte -> all outputs 0 in the same cycle, state IDLE; a following start plus 11 bytes commits correctly.
- With T_DEMUX_ADDR_WRITE_EN: wr_sel=3, wr_data=0x55 -> y3=0x55 next cycle; wr_sel=12 -> no change; a write to y5 on the COMMIT edge -> y5 takes the shadow value.

Source files
------------

// File: rtl/t_mix_pkg.sv
// Shared definitions for the 11-channel byte mixing blocks (selector and demux).
// Channel count, pointer width and the demux frame FSM state encoding live here.
package t_mix_pkg;

    localparam int NUM_CH = 11;
    localparam int CH_W = 4;
    localparam logic [CH_W-1:0] LAST_CH = 4'hA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/t_demux_shadow_bank.sv
// 11-entry shadow register file: one indexed write port, all entries read in parallel.
// Holds a frame while it is being assembled so the outputs never see partial data.
module t_demux_shadow_bank
    import t_mix_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [CH_W-1:0]               idx,
    input  logic [DATA_W-1:0]             wdata,
    output logic [NUM_CH-1:0][DATA_W-1:0] q
);

    // Out-of-range indices are dropped so slots 11..15 never alias a real entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (we && (idx <= LAST_CH)) begin
            q[idx] <= wdata;
        end
    end

endmodule

// File: rtl/t_demux_1x11.sv
// Frame-based 1-to-11 byte distributor: fills a shadow bank from a valid/ready stream
// and commits all 11 outputs together. Optional direct writes: T_DEMUX_ADDR_WRITE_EN.
module t_demux_1x11 #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
`ifdef T_DEMUX_ADDR_WRITE_EN
    input  logic              wr_en,
    input  logic [3:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
`endif
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3,
    output logic [DATA_W-1:0] y4,
    output logic [DATA_W-1:0] y5,
    output logic [DATA_W-1:0] y6,
    output logic [DATA_W-1:0] y7,
    output logic [DATA_W-1:0] y8,
    output logic [DATA_W-1:0] y9,
    output logic [DATA_W-1:0] y10,
    output logic [3:0]        ptr,
    output logic              busy,
    output logic              frame_done
);

    import t_mix_pkg::*;

    state_t state;
    state_t next_state;
    logic [CH_W-1:0] ptr_next;
    logic shadow_we;
    logic [NUM_CH-1:0][DATA_W-1:0] shadow;
    logic [NUM_CH-1:0][DATA_W-1:0] yreg;

    t_demux_shadow_bank #(
        .DATA_W(DATA_W)
    ) u_shadow (
        .clk  (clk),
        .reset(reset),
        .we   (shadow_we),
        .idx  (ptr),
        .wdata(din),
        .q    (shadow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= ptr_next;
        end
    end

    // A start seen in FILL rewinds the pointer and drops any byte offered that cycle
    always_comb begin
        next_state = state;
        ptr_next   = ptr;
        din_ready  = 1'b0;
        shadow_we  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FILL;
                    ptr_next   = '0;
                end
            end
            FILL: begin
                din_ready = 1'b1;
                if (start) begin
                    ptr_next = '0;
                end else if (din_valid) begin
                    shadow_we = 1'b1;
                    if (ptr == LAST_CH) begin
                        ptr_next   = '0;
                        next_state = COMMIT;
                    end else begin
                        ptr_next = ptr + 4'd1;
                    end
                end
            end
            COMMIT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // Commit is placed after the direct write so it takes priority on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            yreg       <= '0;
            frame_done <= 1'b0;
        end else begin
`ifdef T_DEMUX_ADDR_WRITE_EN
            if (wr_en && (wr_sel <= LAST_CH)) begin
                yreg[wr_sel] <= wr_data;
            end
`endif
            if (state == COMMIT) begin
                yreg <= shadow;
            end
            frame_done <= (state == COMMIT);
        end
    end

    assign busy = (state != IDLE);

    assign y0  = yreg[0];
    assign y1  = yreg[1];
    assign y2  = yreg[2];
    assign y3  = yreg[3];
    assign y4  = yreg[4];
    assign y5  = yreg[5];
    assign y6  = yreg[6];
    assign y7  = yreg[7];
    assign y8  = yreg[8];
    assign y9  = yreg[9];
    assign y10 = yreg[10];

endmodule

// File: tb/tb_t_demux_1x11.sv
// Self-checking bench for t_demux_1x11: expected frames are queued as they are sent
// and compared when frame_done pulses. Define T_DEMUX_ADDR_WRITE_EN for direct writes.
module tb_t_demux_1x11;

    typedef logic [10:0][7:0] frame_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [7:0] din;
    logic din_valid;
    logic din_ready;
    logic [7:0] y0, y1, y2, y3, y4, y5, y6, y7, y8, y9, y10;
    logic [3:0] ptr;
    logic busy;
    logic frame_done;
`ifdef T_DEMUX_ADDR_WRITE_EN
    logic wr_en;
    logic [3:0] wr_sel;
    logic [7:0] wr_data;
`endif

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int lastAcceptCycle = 0;
    int framesSeen = 0;
    int framesExpected = 0;
    int readyCount;
    bit collideNext = 1'b0;
    frame_t expQ[$];
    frame_t committed = '0;
    frame_t monExp;
    frame_t fa, fb, fr, fi, fc;
    frame_t yv;

    assign yv = {y10, y9, y8, y7, y6, y5, y4, y3, y2, y1, y0};

    t_demux_1x11 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
`ifdef T_DEMUX_ADDR_WRITE_EN
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
`endif
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y4        (y4),
        .y5        (y5),
        .y6        (y6),
        .y7        (y7),
        .y8        (y8),
        .y9        (y9),
        .y10       (y10),
        .ptr       (ptr),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic applyStimulus(input frame_t bytes, input int count, input bit gapped, input bit pushExp);
        bit accepted;
        bit rdy;
        for (int k = 0; k < count; k++) begin
            din = bytes[k];
            din_valid = 1'b1;
            accepted = 1'b0;
            for (int w = 0; w < 50 && !accepted; w++) begin
                @(negedge clk);
                rdy = din_ready;
                @(posedge clk);
                #1;
                if (rdy) accepted = 1'b1;
            end
            if (!accepted) checkOutput("acceptTimeout", 0, 1);
            if (k == 10) begin
                lastAcceptCycle = cycle;
                if (pushExp) begin
                    expQ.push_back(bytes);
                    framesExpected++;
                end
`ifdef T_DEMUX_ADDR_WRITE_EN
                if (collideNext) begin
                    wr_en = 1'b1;
                    wr_sel = 4'd5;
                    wr_data = 8'hEE;
                end
`endif
            end
            if (gapped) begin
                din_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every frame_done must match the oldest queued frame, one cycle after its last accept
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && frame_done === 1'b1) begin
                framesSeen++;
                if (expQ.size() == 0) begin
                    checkOutput("spuriousFrameDone", 1, 0);
                end else begin
                    monExp = expQ.pop_front();
                    for (int i = 0; i < 11; i++) begin
                        checkOutput($sformatf("y%0d", i), 32'(yv[i]), 32'(monExp[i]));
                    end
                    checkOutput("doneLatency", cycle - lastAcceptCycle, 1);
                    checkOutput("busyAtDone", 32'(busy), 0);
                    checkOutput("ptrAtDone", 32'(ptr), 0);
                    committed = monExp;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 11; i++) begin
            fa[i] = 8'h10 + 8'(i);
            fb[i] = 8'h20 + 8'(i);
            fr[i] = (i < 5) ? 8'hA0 + 8'(i) : 8'h00;
            fi[i] = 8'(i);
            fc[i] = 8'hC0 + 8'(i);
        end
        reset = 1'b1;
        start = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
`ifdef T_DEMUX_ADDR_WRITE_EN
        wr_en = 1'b0;
        wr_sel = 4'd0;
        wr_data = 8'h00;
`endif
        waitCycles(2);
        reset = 1'b0;

        $display("[TB] reset state and idle with din_valid held");
        checkOutput("resetY", 32'(yv == '0), 1);
        checkOutput("resetPtr", 32'(ptr), 0);
        checkOutput("resetBusy", 32'(busy), 0);
        checkOutput("resetReady", 32'(din_ready), 0);
        checkOutput("resetDone", 32'(frame_done), 0);
        din = 8'h77;
        din_valid = 1'b1;
        readyCount = 0;
        repeat (20) begin
            @(negedge clk);
            if (din_ready) readyCount++;
        end
        din_valid = 1'b0;
        checkOutput("idleReadyCount", readyCount, 0);
        checkOutput("idleY", 32'(yv == '0), 1);
        checkOutput("idleBusy", 32'(busy), 0);
        waitCycles(1);

        $display("[TB] full back-to-back frame");
        pulseStart();
        checkOutput("busyInFill", 32'(busy), 1);
        checkOutput("readyInFill", 32'(din_ready), 1);
        applyStimulus(fa, 11, 1'b0, 1'b1);
        waitCycles(3);
        checkOutput("busyAfterFull", 32'(busy), 0);

        $display("[TB] gapped frame");
        pulseStart();
        applyStimulus(fb, 11, 1'b1, 1'b1);
        waitCycles(3);

        $display("[TB] restart mid-frame");
        pulseStart();
        applyStimulus(fr, 5, 1'b0, 1'b0);
        checkOutput("ptrBeforeRestart", 32'(ptr), 5);
        din = 8'hFF;
        din_valid = 1'b1;
        pulseStart();
        din_valid = 1'b0;
        checkOutput("ptrAfterRestart", 32'(ptr), 0);
        checkOutput("yHeldOnRestart", 32'(yv == committed), 1);
        applyStimulus(fi, 11, 1'b0, 1'b1);
        waitCycles(3);

        $display("[TB] asynchronous reset mid-frame");
        pulseStart();
        applyStimulus(fc, 6, 1'b0, 1'b0);
        checkOutput("yHeldDuringFill", 32'(yv == committed), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncY", 32'(yv == '0), 1);
        checkOutput("asyncPtr", 32'(ptr), 0);
        checkOutput("asyncBusy", 32'(busy), 0);
        checkOutput("asyncReady", 32'(din_ready), 0);
        committed = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        waitCycles(1);
        pulseStart();
        applyStimulus(fc, 11, 1'b0, 1'b1);
        waitCycles(3);

`ifdef T_DEMUX_ADDR_WRITE_EN
        $display("[TB] direct channel writes");
        wr_en = 1'b1;
        wr_sel = 4'd3;
        wr_data = 8'h55;
        @(posedge clk);
        #1 wr_en = 1'b0;
        committed[3] = 8'h55;
        checkOutput("directY3", 32'(y3), 32'h55);
        checkOutput("directOthers", 32'(yv == committed), 1);
        wr_en = 1'b1;
        wr_sel = 4'd12;
        wr_data = 8'h99;
        @(posedge clk);
        #1 wr_en = 1'b0;
        checkOutput("directIgnored", 32'(yv == committed), 1);
        collideNext = 1'b1;
        pulseStart();
        applyStimulus(fa, 11, 1'b0, 1'b1);
        @(posedge clk);
        #1 wr_en = 1'b0;
        collideNext = 1'b0;
        waitCycles(3);
        checkOutput("collideY5", 32'(y5), 32'h15);
`endif

        checkOutput("framesSeen", framesSeen, framesExpected);
        checkOutput("queueEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
